// File: rtl/decode_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decode_alu_ctrl
// Purpose  : RV32I(M) decode stage. Produces the ALU select code, immediate,
//            register indices and control flags one cycle after accept,
//            behind a 2-entry skid buffer. Optional macro: M_EXT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module decode_alu_ctrl (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] IN_INSTR,
    input  logic [31:0] IN_PC,
    input  logic        FLUSH,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_PC,
    output logic [5:0]  ALU_SELECT,
    output logic [31:0] IMM,
    output logic [4:0]  RS1,
    output logic [4:0]  RS2,
    output logic [4:0]  RD,
    output logic [2:0]  FUNCT3,
    output logic        OP1_PC,
    output logic        OP2_IMM,
    output logic        REG_WRITE_EN,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic        BRANCH,
    output logic        JUMP,
    output logic        ILLEGAL
);

    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;

    localparam logic [5:0] C_ALU_ADD = 6'b000000;
    localparam logic [5:0] C_ALU_SUB = 6'b010000;
    localparam logic [5:0] C_ALU_SRA = 6'b010101;
    localparam logic [5:0] C_ALU_FWD = 6'b011000;

    localparam logic [6:0] C_F7_BASE = 7'b0000000;
    localparam logic [6:0] C_F7_ALT  = 7'b0100000;
    localparam logic [6:0] C_F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  alu;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        op1_pc;
        logic        op2_imm;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        jump;
        logic        illegal;
    } bundle_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_sh;
    logic        dec_illegal;
    bundle_t     dec;

    assign opcode = IN_INSTR[6:0];
    assign funct3 = IN_INSTR[14:12];
    assign funct7 = IN_INSTR[31:25];

    assign imm_i  = {{20{IN_INSTR[31]}}, IN_INSTR[31:20]};
    assign imm_s  = {{20{IN_INSTR[31]}}, IN_INSTR[31:25], IN_INSTR[11:7]};
    assign imm_b  = {{19{IN_INSTR[31]}}, IN_INSTR[31], IN_INSTR[7],
                     IN_INSTR[30:25], IN_INSTR[11:8], 1'b0};
    assign imm_u  = {IN_INSTR[31:12], 12'b0};
    assign imm_j  = {{11{IN_INSTR[31]}}, IN_INSTR[31], IN_INSTR[19:12],
                     IN_INSTR[20], IN_INSTR[30:21], 1'b0};
    assign imm_sh = {27'b0, IN_INSTR[24:20]};

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        dec.pc      = IN_PC;
        dec.rs1     = IN_INSTR[19:15];
        dec.rs2     = IN_INSTR[24:20];
        dec.rd      = IN_INSTR[11:7];
        dec.funct3  = funct3;

        case (opcode)
            C_OPC_OP: begin
                dec.reg_we = 1'b1;
                case (funct7)
                    C_F7_BASE: dec.alu = {3'b000, funct3};
                    C_F7_ALT: begin
                        if (funct3 == 3'b000) begin
                            dec.alu = C_ALU_SUB;
                        end else if (funct3 == 3'b101) begin
                            dec.alu = C_ALU_SRA;
                        end else begin
                            dec_illegal = 1'b1;
                        end
                    end
                    C_F7_MULDIV: begin
`ifdef M_EXT_EN
                        dec.alu = {3'b001, funct3};
`else
                        dec_illegal = 1'b1;
`endif
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            C_OPC_OP_IMM: begin
                dec.reg_we  = 1'b1;
                dec.op2_imm = 1'b1;
                dec.alu     = {3'b000, funct3};
                dec.imm     = imm_i;
                // instr[31:25] only carries an encoding for the shift forms;
                // elsewhere it is the upper part of the I-immediate.
                if (funct3 == 3'b001) begin
                    dec.imm = imm_sh;
                    if (funct7 != C_F7_BASE) begin
                        dec_illegal = 1'b1;
                    end
                end else if (funct3 == 3'b101) begin
                    dec.imm = imm_sh;
                    if (funct7 == C_F7_ALT) begin
                        dec.alu = C_ALU_SRA;
                    end else if (funct7 != C_F7_BASE) begin
                        dec_illegal = 1'b1;
                    end
                end
            end
            C_OPC_LUI: begin
                dec.alu     = C_ALU_FWD;
                dec.imm     = imm_u;
                dec.op2_imm = 1'b1;
                dec.reg_we  = 1'b1;
            end
            C_OPC_AUIPC: begin
                dec.alu     = C_ALU_ADD;
                dec.imm     = imm_u;
                dec.op1_pc  = 1'b1;
                dec.op2_imm = 1'b1;
                dec.reg_we  = 1'b1;
            end
            C_OPC_LOAD: begin
                dec.alu     = C_ALU_ADD;
                dec.imm     = imm_i;
                dec.op2_imm = 1'b1;
                dec.mem_rd  = 1'b1;
                dec.reg_we  = 1'b1;
            end
            C_OPC_STORE: begin
                dec.alu     = C_ALU_ADD;
                dec.imm     = imm_s;
                dec.op2_imm = 1'b1;
                dec.mem_wr  = 1'b1;
            end
            C_OPC_BRANCH: begin
                dec.alu     = C_ALU_ADD;
                dec.imm     = imm_b;
                dec.op1_pc  = 1'b1;
                dec.op2_imm = 1'b1;
                dec.branch  = 1'b1;
            end
            C_OPC_JAL: begin
                dec.alu     = C_ALU_ADD;
                dec.imm     = imm_j;
                dec.op1_pc  = 1'b1;
                dec.op2_imm = 1'b1;
                dec.jump    = 1'b1;
                dec.reg_we  = 1'b1;
            end
            C_OPC_JALR: begin
                dec.alu     = C_ALU_ADD;
                dec.imm     = imm_i;
                dec.op2_imm = 1'b1;
                dec.jump    = 1'b1;
                dec.reg_we  = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase

        // An undecodable word must not trigger any datapath side effect.
        if (dec_illegal) begin
            dec.alu     = C_ALU_ADD;
            dec.imm     = '0;
            dec.op1_pc  = 1'b0;
            dec.op2_imm = 1'b0;
            dec.reg_we  = 1'b0;
            dec.mem_rd  = 1'b0;
            dec.mem_wr  = 1'b0;
            dec.branch  = 1'b0;
            dec.jump    = 1'b0;
            dec.illegal = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Two-entry skid buffer: main drives the outputs, skid absorbs one
    // accept made while main is stalled.
    // ------------------------------------------------------------------
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    logic    main_valid_q, main_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    in_ready_q, in_ready_d;
    logic    accept;
    logic    emit;

    assign accept = IN_VALID && in_ready_q && !FLUSH;
    assign emit   = main_valid_q && OUT_READY;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (FLUSH) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || emit) begin
            // Skid is only ever occupied while main is, and accept is
            // blocked while skid is occupied, so at most one source applies.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
            end else if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
            skid_valid_d = 1'b0;
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign IN_READY     = in_ready_q;
    assign OUT_VALID    = main_valid_q;
    assign OUT_PC       = main_q.pc;
    assign ALU_SELECT   = main_q.alu;
    assign IMM          = main_q.imm;
    assign RS1          = main_q.rs1;
    assign RS2          = main_q.rs2;
    assign RD           = main_q.rd;
    assign FUNCT3       = main_q.funct3;
    assign OP1_PC       = main_q.op1_pc;
    assign OP2_IMM      = main_q.op2_imm;
    assign REG_WRITE_EN = main_q.reg_we;
    assign MEM_READ     = main_q.mem_rd;
    assign MEM_WRITE    = main_q.mem_wr;
    assign BRANCH       = main_q.branch;
    assign JUMP         = main_q.jump;
    assign ILLEGAL      = main_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_alu_ctrl
// Purpose  : Directed scoreboard bench for decode_alu_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_alu_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_INSTR;
    logic [31:0] IN_PC;
    logic        FLUSH;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_PC;
    logic [5:0]  ALU_SELECT;
    logic [31:0] IMM;
    logic [4:0]  RS1, RS2, RD;
    logic [2:0]  FUNCT3;
    logic        OP1_PC, OP2_IMM, REG_WRITE_EN, MEM_READ, MEM_WRITE;
    logic        BRANCH, JUMP, ILLEGAL;

    decode_alu_ctrl dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_INSTR(IN_INSTR), .IN_PC(IN_PC), .FLUSH(FLUSH),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_PC(OUT_PC),
        .ALU_SELECT(ALU_SELECT), .IMM(IMM), .RS1(RS1), .RS2(RS2), .RD(RD),
        .FUNCT3(FUNCT3), .OP1_PC(OP1_PC), .OP2_IMM(OP2_IMM),
        .REG_WRITE_EN(REG_WRITE_EN), .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE), .BRANCH(BRANCH), .JUMP(JUMP), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    // flag byte: {op1_pc, op2_imm, reg_we, mem_rd, mem_wr, branch, jump, illegal}
    localparam logic [7:0] F_OP1 = 8'h80;
    localparam logic [7:0] F_IMM = 8'h40;
    localparam logic [7:0] F_RWE = 8'h20;
    localparam logic [7:0] F_MRD = 8'h10;
    localparam logic [7:0] F_MWR = 8'h08;
    localparam logic [7:0] F_BR  = 8'h04;
    localparam logic [7:0] F_JMP = 8'h02;
    localparam logic [7:0] F_ILL = 8'h01;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  alu;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [7:0]  fl;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk(input logic [31:0] pc, input logic [5:0] alu,
                                input logic [31:0] imm, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [7:0] fl);
        exp_t e;
        e.pc = pc; e.alu = alu; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2;
        e.rd = rd; e.f3 = f3; e.fl = fl;
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.pc = OUT_PC; o.alu = ALU_SELECT; o.imm = IMM; o.rs1 = RS1;
        o.rs2 = RS2; o.rd = RD; o.f3 = FUNCT3;
        o.fl = {OP1_PC, OP2_IMM, REG_WRITE_EN, MEM_READ, MEM_WRITE,
                BRANCH, JUMP, ILLEGAL};
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one instruction until accepted; expectation enters the
    // scoreboard on the cycle the DUT takes it.
    task automatic send(input logic [31:0] instr, input exp_t e);
        int  n;
        bit  done;
        IN_VALID = 1'b1;
        IN_INSTR = instr;
        IN_PC    = e.pc;
        done     = 1'b0;
        n        = 0;
        while (!done && n < 20) begin
            @(negedge CLK);
            if (IN_READY) begin
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge CLK);
            #1;
            n++;
        end
        IN_VALID = 1'b0;
        chk("send_accept_timeout", {127'b0, done}, 128'd1);
    endtask

    // Scoreboard consumer: an emit happens at the next edge when valid&&ready.
    always @(negedge CLK) begin
        if (!RESET && !FLUSH && OUT_VALID && OUT_READY) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_emit observed_pc=%h expected=none", OUT_PC);
            end
            if (sb.size() != 0) begin
                exp_t e;
                exp_t o;
                e = sb.pop_front();
                o = observed();
                checks++;
                assert (o === e) else begin
                    failures++;
                    $error("FAIL emit_bundle pc=%h observed=%h expected=%h", e.pc, o, e);
                end
            end
        end
    end

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h407302B3;
    localparam logic [31:0] I_SRAI = 32'h40315093;
    localparam logic [31:0] I_LUI  = 32'h123450B7;
    localparam logic [31:0] I_LW   = 32'hFFC12083;
    localparam logic [31:0] I_MUL  = 32'h023100B3;
    localparam logic [31:0] I_SW   = 32'h0020A423;
    localparam logic [31:0] I_BEQ  = 32'hFE208CE3;
    localparam logic [31:0] I_BADF = 32'h402091B3;
    localparam logic [31:0] I_ZERO = 32'h00000000;

    initial begin
        exp_t e_mul;
        RESET = 1'b1; IN_VALID = 1'b0; IN_INSTR = '0; IN_PC = '0;
        FLUSH = 1'b0; OUT_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;

        @(negedge CLK);
        chk("reset_out_valid", {127'b0, OUT_VALID}, 128'd0);
        chk("reset_in_ready", {127'b0, IN_READY}, 128'd1);
        chk("reset_payload", {32'b0, observed()}, 128'd0);

        @(posedge CLK); #1;
        OUT_READY = 1'b1;

        send(I_ADD, mk(32'h100, 6'b000000, 32'h0, 5'd1, 5'd2, 5'd3, 3'd0, F_RWE));
        chk("latency_one_cycle", {95'b0, OUT_VALID, OUT_PC}, {95'b0, 1'b1, 32'h100});
        send(I_SUB,  mk(32'h104, 6'b010000, 32'h0, 5'd6, 5'd7, 5'd5, 3'd0, F_RWE));
        send(I_SRAI, mk(32'h108, 6'b010101, 32'h3, 5'd2, 5'd3, 5'd1, 3'd5, F_IMM | F_RWE));
        send(I_LUI,  mk(32'h10C, 6'b011000, 32'h12345000, 5'd8, 5'd3, 5'd1, 3'd5, F_IMM | F_RWE));
        send(I_LW,   mk(32'h110, 6'b000000, 32'hFFFFFFFC, 5'd2, 5'd28, 5'd1, 3'd2,
                        F_IMM | F_RWE | F_MRD));
`ifdef M_EXT_EN
        e_mul = mk(32'h114, 6'b001000, 32'h0, 5'd2, 5'd3, 5'd1, 3'd0, F_RWE);
`else
        e_mul = mk(32'h114, 6'b000000, 32'h0, 5'd2, 5'd3, 5'd1, 3'd0, F_ILL);
`endif
        send(I_MUL, e_mul);
        send(I_SW,   mk(32'h118, 6'b000000, 32'h8, 5'd1, 5'd2, 5'd8, 3'd2, F_IMM | F_MWR));
        send(I_BEQ,  mk(32'h11C, 6'b000000, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd25, 3'd0,
                        F_OP1 | F_IMM | F_BR));
        send(I_BADF, mk(32'h120, 6'b000000, 32'h0, 5'd1, 5'd2, 5'd3, 3'd1, F_ILL));
        send(I_ZERO, mk(32'h124, 6'b000000, 32'h0, 5'd0, 5'd0, 5'd0, 3'd0, F_ILL));
        repeat (2) @(posedge CLK);
        #1;

        // Back-pressure: two accepts fill both entries, third is held off.
        OUT_READY = 1'b0;
        send(I_ADD, mk(32'h200, 6'b000000, 32'h0, 5'd1, 5'd2, 5'd3, 3'd0, F_RWE));
        send(I_SUB, mk(32'h204, 6'b010000, 32'h0, 5'd6, 5'd7, 5'd5, 3'd0, F_RWE));
        IN_VALID = 1'b1; IN_INSTR = I_SW; IN_PC = 32'h208;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("stall_in_ready_low", {127'b0, IN_READY}, 128'd0);
        end
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        @(negedge CLK);
        chk("release_first_add", {122'b0, OUT_VALID, RD}, {122'b0, 1'b1, 5'd3});
        @(negedge CLK);
        chk("release_second_sub", {122'b0, OUT_VALID, RD}, {122'b0, 1'b1, 5'd5});
        chk("release_in_ready", {127'b0, IN_READY}, 128'd1);
        if (IN_READY)
            sb.push_back(mk(32'h208, 6'b000000, 32'h8, 5'd1, 5'd2, 5'd8, 3'd2, F_IMM | F_MWR));
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("drain_scoreboard_empty", 128'(sb.size()), 128'd0);
        @(posedge CLK); #1;

        // Flush with both entries full and a live input.
        OUT_READY = 1'b0;
        send(I_ADD, mk(32'h300, 6'b000000, 32'h0, 5'd1, 5'd2, 5'd3, 3'd0, F_RWE));
        send(I_SUB, mk(32'h304, 6'b010000, 32'h0, 5'd6, 5'd7, 5'd5, 3'd0, F_RWE));
        IN_VALID = 1'b1; IN_INSTR = I_LUI; IN_PC = 32'h308; FLUSH = 1'b1;
        @(posedge CLK); #1;
        FLUSH = 1'b0; IN_VALID = 1'b0;
        sb.delete();
        @(negedge CLK);
        chk("flush_out_valid", {127'b0, OUT_VALID}, 128'd0);
        chk("flush_in_ready", {127'b0, IN_READY}, 128'd1);
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("flush_no_emit", {127'b0, OUT_VALID}, 128'd0);
        end

        // Reset while stalled with both entries held.
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        send(I_LW,  mk(32'h400, 6'b000000, 32'hFFFFFFFC, 5'd2, 5'd28, 5'd1, 3'd2,
                       F_IMM | F_RWE | F_MRD));
        send(I_BEQ, mk(32'h404, 6'b000000, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd25, 3'd0,
                       F_OP1 | F_IMM | F_BR));
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        sb.delete();
        @(negedge CLK);
        chk("midreset_out_valid", {127'b0, OUT_VALID}, 128'd0);
        chk("midreset_in_ready", {127'b0, IN_READY}, 128'd1);
        chk("midreset_payload", {32'b0, observed()}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_alu_ctrl.md
# decode_alu_ctrl

Pipelined RV32IM instruction decode stage and the producer of the 6-bit operation select consumed by the CPU ALU. Accepts fetched instructions on a valid/ready handshake and emits, one cycle later, the ALU select code, sign-extended immediate, register indices and datapath control flags. A 2-entry skid buffer holds the output, so the registered input-ready never throttles throughput. A flush input lets the hazard/branch logic discard in-flight instructions.

## Interface
- No parameters. Widths are fixed by RV32.
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- IN_VALID  in  1  instruction present on IN_INSTR/IN_PC.
- IN_READY  out  1  registered; stage can accept this cycle.
- IN_INSTR  in  32  raw instruction word.
- IN_PC  in  32  PC of IN_INSTR.
- FLUSH  in  1  discard all held entries and any same-cycle input.
- OUT_VALID  out  1  decoded bundle valid.
- OUT_READY  in  1  downstream (execute) accepts bundle.
- OUT_PC  out  32  PC of the decoded instruction.
- ALU_SELECT  out  6  ALU operation code (encoding below).
- IMM  out  32  decoded immediate.
- RS1, RS2, RD  out  5 each  register indices (instr[19:15], [24:20], [11:7]).
- FUNCT3  out  3  instr[14:12], for the branch/load-store units.
- OP1_PC  out  1  ALU operand 1 = PC (AUIPC, JAL, branches) else RS1 data.
- OP2_IMM  out  1  ALU operand 2 = IMM, else RS2 data.
- REG_WRITE_EN, MEM_READ, MEM_WRITE, BRANCH, JUMP  out  1 each  control flags.
- ILLEGAL  out  1  undecodable instruction. All other control flags are forced to 0 when set.

## Operation
- ALU_SELECT encoding:
  - 000000 ADD, 000001 SLL, 000010 SLT, 000011 SLTU, 000100 XOR, 000101 SRL, 000110 OR, 000111 AND.
  - 001000–001111: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (low 3 bits = funct3).
  - 010000 SUB, 010101 SRA, 011000 FWD (pass operand 2).
- OP (0110011):
  - funct7=0000000 → {000,funct3}.
  - funct7=0100000 with funct3 000/101 → 010000/010101.
  - funct7=0000001 → {001,funct3}.
  - Anything else → ILLEGAL.
- OP-IMM (0010011): {000,funct3}, OP2_IMM=1. SRAI (funct3=101, instr[30]=1) → 010101. Shifts set IMM={27'b0,instr[24:20]}. Nonzero instr[31:25] other than SRAI → ILLEGAL.
- LUI: FWD, IMM = U-type.
- AUIPC: ADD, OP1_PC=1.
- LOAD: ADD, I-imm, MEM_READ=1.
- STORE: ADD, S-imm, MEM_WRITE=1, REG_WRITE_EN=0.
- BRANCH: ADD (target), B-imm, OP1_PC=1, BRANCH=1.
- JAL: ADD, J-imm, OP1_PC=1, JUMP=1.
- JALR: ADD, I-imm, JUMP=1.
- REG_WRITE_EN=1 for OP, OP-IMM, LUI, AUIPC, LOAD, JAL, JALR.
- Any other opcode → ILLEGAL, ALU_SELECT=000000.
- All immediates are sign-extended from instr[31], except shift amounts (zero-extended) and U-type (low 12 bits zero).

## Timing
- Latency: 1 cycle. A bundle accepted at edge N is on the outputs after edge N.
- Accept occurs when IN_VALID && IN_READY && !FLUSH. Emit occurs when OUT_VALID && OUT_READY.
- Storage: main entry drives outputs; skid entry catches an accept made while main is stalled.
- IN_READY = !skid_valid, registered.
- On emit with skid valid, skid moves to main on the same edge. Order is strictly preserved.
- Simultaneous accept and emit with skid empty: the new bundle goes directly into main.
- FLUSH: both valids clear at the next edge. A same-cycle input is dropped, and IN_READY is 1 on the following cycle. FLUSH has priority over accept and emit.
- Reset values: OUT_VALID=0, IN_READY=1, both entries invalid, all payload outputs 0 (ALU_SELECT=000000, ILLEGAL=0).
- RESET asserted mid-stall discards all held bundles.
- Payload outputs are stable while OUT_VALID && !OUT_READY.

## Configuration
- M_EXT_EN defined: funct7=0000001 under OP decodes to 001xxx.
- M_EXT_EN undefined: those encodings set ILLEGAL=1 with ALU_SELECT=000000, and no 001xxx code is ever emitted.

## Test plan
- 0x002081B3 (add x3,x1,x2), OUT_READY=1 → next cycle ALU_SELECT=000000, RS1=1, RS2=2, RD=3, REG_WRITE_EN=1, OP2_IMM=0.
- 0x407302B3 (sub x5,x6,x7) → 010000. 0x40315093 (srai x1,x2,3) → 010101, IMM=0x00000003, OP2_IMM=1.
- 0x123450B7 (lui x1,0x12345) → 011000, IMM=0x12345000. 0xFFC12083 (lw x1,-4(x2)) → 000000, IMM=0xFFFFFFFC, MEM_READ=1.
- 0x023100B3 (mul x1,x2,x3) → with M_EXT_EN 001000, ILLEGAL=0. Without it, ILLEGAL=1 and REG_WRITE_EN=0.
- OUT_READY=0 for 3 cycles while sending add then sub back-to-back:
  - IN_READY falls after the second accept and the third instruction is held off.
  - On release, add then sub are emitted on consecutive cycles, with no loss or duplication.
- FLUSH with both entries full plus IN_VALID=1:
  - OUT_VALID=0 next cycle and IN_READY=1.
  - The dropped input is never emitted.
  - Then RESET mid-stall → all outputs 0.
